// File: rtl/prores_bitstream_pkg.sv
// Shared definitions for the ProRes bitstream packing path: widths, packer
// FSM states and the codeword record handed from the mask decoder to the
// packer.
package prores_bitstream_pkg;

    localparam int IN_W  = 24;   // codeword / output_enable mask width
    localparam int OUT_W = 32;   // packed output word width
    localparam int ACC_W = 64;   // accumulator width, >= OUT_W + IN_W + 8
    localparam int CNT_W = 7;    // holds a bit count of 0..ACC_W

    // Largest fill level at which another full-width codeword still fits.
    localparam logic [CNT_W-1:0] FILL_LIMIT = CNT_W'(ACC_W - IN_W);
    localparam logic [CNT_W-1:0] WORD_BITS  = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] ACC_BITS   = CNT_W'(ACC_W);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        LAST  = 2'd2
    } pack_state_t;

    typedef struct packed {
        logic [IN_W-1:0] code;
        logic [4:0]      len;
    } codeword_t;

endpackage

// File: rtl/mask_to_len.sv
// Highest-set-bit encoder: turns an entropy encoder output_enable mask into
// a codeword length (index of the highest set bit + 1, zero for an empty
// mask). Holes below the top set bit do not shorten the length.
module mask_to_len
    import prores_bitstream_pkg::*;
(
    input  logic [IN_W-1:0] mask,
    output logic [4:0]      len
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        len = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (mask[i]) begin
                len = 5'(i + 1);
            end
        end
    end

endmodule

// File: rtl/bitstream_packer.sv
// Bitstream packer: concatenates variable-length codewords MSB-first into a
// 64-bit accumulator and hands off 32-bit words over valid/ready. A flush
// zero-pads the tail, tags it as the last word and pulses flush_done once the
// slice is closed.
// Optional: define BITSTREAM_PACKER_STATS_EN to add stat_bits / stat_words
// saturating counters (cleared on reset and on flush_done).
module bitstream_packer
    import prores_bitstream_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic [IN_W-1:0]  in_mask,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [5:0]       out_nbits,
    output logic             flush_done
`ifdef BITSTREAM_PACKER_STATS_EN
    ,
    output logic [31:0]      stat_bits,
    output logic [15:0]      stat_words
`endif
);

    pack_state_t      state, state_n;
    logic [ACC_W-1:0] acc, acc_d, acc_n, code_ext;
    logic [CNT_W-1:0] count, cnt_d, cnt_n, ins_sh;
    logic [4:0]       mask_len;
    logic [IN_W-1:0]  len_mask;
    codeword_t        cw;
    logic             accept;
    logic             out_free;
    logic             can_drain;
    logic             tail_load;
    logic             flush_done_n;
    logic             in_ready_n;

    mask_to_len u_mask_to_len (
        .mask (in_mask),
        .len  (mask_len)
    );

    // Strip code bits above the decoded length so stray encoder bits never
    // leak into the stream.
    assign len_mask = {IN_W{1'b1}} >> (5'(IN_W) - mask_len);
    assign cw       = {in_code & len_mask, mask_len};
    assign code_ext = {{(ACC_W-IN_W){1'b0}}, cw.code};

    assign accept    = in_valid & in_ready;
    assign out_free  = ~out_valid | out_ready;
    assign can_drain = out_free & (count >= WORD_BITS);

    // Accumulator update: drain first, then append below the remaining bits
    // so a same-cycle drain and append keep stream order.
    always_comb begin
        acc_d = acc;
        cnt_d = count;
        if (can_drain) begin
            acc_d = acc << OUT_W;
            cnt_d = count - WORD_BITS;
        end
        ins_sh = ACC_BITS - cnt_d - CNT_W'(cw.len);
        acc_n  = acc_d;
        cnt_n  = cnt_d;
        if (accept) begin
            acc_n = acc_d | (code_ext << ins_sh);
            cnt_n = cnt_d + CNT_W'(cw.len);
        end
        if (tail_load) begin
            acc_n = '0;
            cnt_n = '0;
        end
    end

    // Packer FSM next-state: RUN accepts codewords, FLUSH drains and emits
    // the padded tail, LAST waits for the tail word to be taken.
    always_comb begin
        state_n      = state;
        tail_load    = 1'b0;
        flush_done_n = 1'b0;
        case (state)
            RUN: begin
                if (flush) begin
                    state_n = FLUSH;
                end
            end
            FLUSH: begin
                if (out_free && (count < WORD_BITS)) begin
                    if (count != '0) begin
                        tail_load = 1'b1;
                        state_n   = LAST;
                    end else begin
                        flush_done_n = 1'b1;
                        state_n      = RUN;
                    end
                end
            end
            LAST: begin
                if (out_valid && out_ready) begin
                    flush_done_n = 1'b1;
                    state_n      = RUN;
                end
            end
            default: begin
                state_n = RUN;
            end
        endcase
        in_ready_n = (state_n == RUN) && (cnt_n <= FILL_LIMIT);
    end

    // State, accumulator and input-side handshake registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            acc        <= '0;
            count      <= '0;
            in_ready   <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            count      <= cnt_n;
            in_ready   <= in_ready_n;
            flush_done <= flush_done_n;
        end
    end

    // Output word register: holds its contents while stalled, loads a full
    // word or the padded tail when free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_nbits <= '0;
        end else if (can_drain) begin
            out_valid <= 1'b1;
            out_data  <= acc[ACC_W-1 -: OUT_W];
            out_last  <= 1'b0;
            out_nbits <= 6'(OUT_W);
        end else if (tail_load) begin
            out_valid <= 1'b1;
            out_data  <= acc[ACC_W-1 -: OUT_W];
            out_last  <= 1'b1;
            out_nbits <= count[5:0];
        end else if (out_free) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef BITSTREAM_PACKER_STATS_EN
    function automatic logic [31:0] sat_add_bits(input logic [31:0] a,
                                                 input logic [4:0]  b);
        logic [32:0] s;
        s = {1'b0, a} + {28'b0, b};
        return s[32] ? {32{1'b1}} : s[31:0];
    endfunction

    function automatic logic [15:0] sat_inc_words(input logic [15:0] a);
        return (a == {16{1'b1}}) ? a : a + 16'd1;
    endfunction

    // Per-slice statistics; cleared together with the flush_done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_bits  <= '0;
            stat_words <= '0;
        end else if (flush_done_n) begin
            stat_bits  <= '0;
            stat_words <= '0;
        end else begin
            if (accept) begin
                stat_bits <= sat_add_bits(stat_bits, cw.len);
            end
            if (out_valid && out_ready) begin
                stat_words <= sat_inc_words(stat_words);
            end
        end
    end
`endif

endmodule
